// File: rtl/bus_pkg.sv
// Shared bus definitions used by the receive endpoint and the transmit-side bus agents.
package bus_pkg;

  localparam int unsigned ID_W      = 8;
  localparam int unsigned STAT_W    = 16;
  localparam int unsigned PKT_MAX_W = 64;
  localparam logic [ID_W-1:0] BCAST_ID = 8'hFF;

  typedef logic [STAT_W-1:0] stat_t;

  // Destination ID sits in the top ID_W bits of a pkt_w-bit packet.
  function automatic logic [ID_W-1:0] pkt_id(input logic [PKT_MAX_W-1:0] pkt,
                                             input int unsigned pkt_w);
    logic [PKT_MAX_W-1:0] sh;
    sh = pkt >> (pkt_w - ID_W);
    return sh[ID_W-1:0];
  endfunction

  function automatic stat_t sat_inc(input stat_t v);
    return (v == '1) ? v : v + stat_t'(1);
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO; occupancy is tracked by a counter, never by pointer compare.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} fifo_state_e;

  fifo_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [AW-1:0]        wptr_q, rptr_q;
  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic                 do_wr, do_rd;

  // A write into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_rd = rd_en && (state_q != EMPTY);
  assign do_wr = wr_en && ((state_q != FULL) || do_rd);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (do_wr) begin
        mem_q[wptr_q] <= wr_data;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (do_rd) rptr_q <= rptr_q + AW'(1);
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    if (do_wr && !do_rd)      cnt_d = cnt_q + CW'(1);
    else if (do_rd && !do_wr) cnt_d = cnt_q - CW'(1);
    case (state_q)
      EMPTY:   if (do_wr) state_d = PARTIAL;
      PARTIAL: begin
        if (do_wr && !do_rd && cnt_q == CW'(DEPTH - 1)) state_d = FULL;
        else if (do_rd && !do_wr && cnt_q == CW'(1))    state_d = EMPTY;
      end
      FULL:    if (do_rd && !do_wr) state_d = PARTIAL;
      default: state_d = EMPTY;
    endcase
  end

  assign rd_data = mem_q[rptr_q];
  assign full    = (state_q == FULL);
  assign empty   = (state_q == EMPTY);
  assign count   = cnt_q;

endmodule

// File: rtl/bus_rx_endpoint.sv
// Receive endpoint: ID filter, FWFT buffering toward the local consumer, and per-endpoint statistics.
module bus_rx_endpoint
  import bus_pkg::*;
#(
  parameter int unsigned drvrs    = 4,
  parameter int unsigned pckg_sz  = 16,
  parameter logic [7:0]  MY_ID    = 8'd0,
  parameter int unsigned DEPTH    = 4,
  parameter logic [7:0]  BCAST_ID = bus_pkg::BCAST_ID
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [pckg_sz-1:0]       D_push,
  output logic                     out_valid,
  output logic [pckg_sz-1:0]       out_data,
  input  logic                     out_ready,
  output logic                     pndng,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  output stat_t                    rx_cnt,
  output stat_t                    drop_cnt
);

  if (pckg_sz < 9 || pckg_sz > PKT_MAX_W || 32'(MY_ID) >= drvrs ||
      DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("bus_rx_endpoint: illegal parameter set");
  end

  logic [ID_W-1:0] id_c;
  logic            hit, cand, pop, fifo_full, fifo_empty;
  logic            accept, filt_drop, ovf_drop;

  assign id_c      = pkt_id(PKT_MAX_W'(D_push), pckg_sz);
  assign hit       = (id_c == MY_ID) || (id_c == BCAST_ID);
  assign cand      = push && hit;
  assign pop       = out_valid && out_ready;
  assign accept    = cand && (!fifo_full || pop);
  assign filt_drop = push && !hit;
  assign ovf_drop  = cand && fifo_full && !pop;

  sync_fifo_fwft #(
    .WIDTH (pckg_sz),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (cand),
    .wr_data (D_push),
    .rd_en   (out_ready),
    .rd_data (out_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

  assign out_valid = !fifo_empty;
  assign pndng     = out_valid;

  // Each push event bumps exactly one counter; ovf latches the first overflow drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf      <= 1'b0;
      rx_cnt   <= '0;
      drop_cnt <= '0;
    end else begin
      if (accept)                rx_cnt   <= sat_inc(rx_cnt);
      if (filt_drop || ovf_drop) drop_cnt <= sat_inc(drop_cnt);
      if (ovf_drop)              ovf      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_rx_endpoint.sv
// Scoreboard bench for bus_rx_endpoint with MY_ID=2, DEPTH=4, 16-bit packets.
module tb_bus_rx_endpoint;

  logic        clk = 1'b0;
  logic        rst;
  logic        push;
  logic [15:0] D_push;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic        pndng;
  logic [2:0]  count;
  logic        ovf;
  logic [15:0] rx_cnt;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  bus_rx_endpoint #(
    .drvrs   (4),
    .pckg_sz (16),
    .MY_ID   (8'd2),
    .DEPTH   (4),
    .BCAST_ID(8'hFF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .D_push   (D_push),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .pndng    (pndng),
    .count    (count),
    .ovf      (ovf),
    .rx_cnt   (rx_cnt),
    .drop_cnt (drop_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a handshake seen at negedge completes at the next posedge.
  always @(negedge clk) begin
    if (!rst) begin
      check("pndng", 32'(pndng), 32'(out_valid));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_pkt", 32'(out_data), 32'hDEAD_BEEF);
        else check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // Inputs change 1 time unit after posedge and take effect at the next posedge.
  task automatic step(input logic p, input logic [15:0] d, input logic r);
    push = p; D_push = d; out_ready = r;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    exp_q.delete();
    rst = 1'b1;
    step(1'b0, 16'h0, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 1'b0);
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({name, "_empty"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; D_push = '0; out_ready = 1'b0;

    // Reset state and single-packet latency
    do_reset();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data",  32'(out_data), 0);
    check("rst_count", 32'(count), 0);
    check("rst_ovf",   32'(ovf), 0);
    check("rst_rx",    32'(rx_cnt), 0);
    check("rst_drop",  32'(drop_cnt), 0);
    exp_q.push_back(16'h02AB);
    step(1'b1, 16'h02AB, 1'b0);
    check("lat_valid", 32'(out_valid), 1);
    check("lat_data",  32'(out_data), 32'h02AB);
    check("lat_rx",    32'(rx_cnt), 1);
    check("lat_drop",  32'(drop_cnt), 0);
    drain("lat");

    // Filter: foreign ID dropped, broadcast and own ID kept
    do_reset();
    step(1'b1, 16'h01CD, 1'b0);
    exp_q.push_back(16'hFF11); step(1'b1, 16'hFF11, 1'b0);
    exp_q.push_back(16'h0233); step(1'b1, 16'h0233, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    check("flt_count", 32'(count), 2);
    check("flt_head",  32'(out_data), 32'hFF11);
    check("flt_rx",    32'(rx_cnt), 2);
    check("flt_drop",  32'(drop_cnt), 1);
    check("flt_ovf",   32'(ovf), 0);
    drain("flt");

    // Overflow: newest two discarded, contents preserved
    do_reset();
    for (int k = 0; k < 6; k++) begin
      if (k < 4) exp_q.push_back(16'h0200 + 16'(k));
      step(1'b1, 16'h0200 + 16'(k), 1'b0);
    end
    check("ovf_count", 32'(count), 4);
    check("ovf_head",  32'(out_data), 32'h0200);
    check("ovf_drop",  32'(drop_cnt), 2);
    check("ovf_rx",    32'(rx_cnt), 4);
    check("ovf_flag",  32'(ovf), 1);
    drain("ovf");
    check("ovf_sticky", 32'(ovf), 1);

    // Full with simultaneous push and pop
    do_reset();
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(16'h0260 + 16'(k));
      step(1'b1, 16'h0260 + 16'(k), 1'b0);
    end
    exp_q.push_back(16'h0277);
    step(1'b1, 16'h0277, 1'b1);
    check("fpp_count", 32'(count), 4);
    check("fpp_drop",  32'(drop_cnt), 0);
    check("fpp_rx",    32'(rx_cnt), 5);
    check("fpp_ovf",   32'(ovf), 0);
    drain("fpp");

    // Pointer wrap-around
    do_reset();
    for (int r = 0; r < 10; r++) begin
      exp_q.push_back(16'h0200 + 16'(2 * r));
      step(1'b1, 16'h0200 + 16'(2 * r), 1'b0);
      exp_q.push_back(16'h0201 + 16'(2 * r));
      step(1'b1, 16'h0201 + 16'(2 * r), 1'b0);
      step(1'b0, 16'h0, 1'b1);
      step(1'b0, 16'h0, 1'b1);
    end
    step(1'b0, 16'h0, 1'b0);
    check("wrap_rx",    32'(rx_cnt), 20);
    check("wrap_left",  32'(exp_q.size()), 0);
    check("wrap_count", 32'(count), 0);

    // Reset mid-operation flushes everything, including a push in the reset cycle
    do_reset();
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(16'h02A0 + 16'(k));
      step(1'b1, 16'h02A0 + 16'(k), 1'b0);
    end
    check("mid_count_pre", 32'(count), 3);
    exp_q.delete();
    rst = 1'b1;
    step(1'b1, 16'h02EE, 1'b0);
    rst = 1'b0;
    step(1'b0, 16'h0, 1'b0);
    check("mid_count", 32'(count), 0);
    check("mid_valid", 32'(out_valid), 0);
    check("mid_rx",    32'(rx_cnt), 0);
    check("mid_drop",  32'(drop_cnt), 0);
    check("mid_ovf",   32'(ovf), 0);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b1);
    check("mid_nopkt", 32'(out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_rx_endpoint.md
# bus_rx_endpoint

Receive-side endpoint for one device on the shared multi-drop bus. It accepts packets the bus pushes toward a device and keeps those addressed to this device or to broadcast. Accepted packets are buffered in a first-word-fall-through FIFO and handed to the local consumer over a valid/ready handshake. It is the counterpart of the transmit path, where the bus pops packets from a device, and it keeps per-endpoint statistics.

## Interface
- drvrs, 4, number of devices on the bus; legal IDs are 0..drvrs-1
- pckg_sz, 16, packet width in bits; minimum 9
- MY_ID, 0, this endpoint's 8-bit ID
- DEPTH, 4, FIFO depth in packets; power of two, at least 2
- BCAST_ID, 8'hFF, broadcast ID, accepted by every endpoint

- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- push  in  1  bus presents a packet this cycle
- D_push  in  pckg_sz  packet; [pckg_sz-1 -: 8] = destination ID, remainder = payload
- out_valid  out  1  FIFO head is valid
- out_data  out  pckg_sz  FIFO head packet, full packet including ID
- out_ready  in  1  consumer takes the head when out_valid && out_ready
- pndng  out  1  same as out_valid; legacy name used by the bus agents
- count  out  $clog2(DEPTH)+1  current occupancy
- ovf  out  1  sticky; set on the first overflow drop; cleared only by rst
- rx_cnt  out  16  packets written into the FIFO; saturates at 16'hFFFF
- drop_cnt  out  16  packets dropped (filtered or overflow); saturates at 16'hFFFF

## Operation
- Match rule: push && (ID == MY_ID || ID == BCAST_ID) → candidate; other IDs → filtered drop.
- Filtered drop: drop_cnt += 1; FIFO unchanged; ovf unchanged.
- Candidate while FIFO not full, or while full with a pop in the same cycle: written at the tail; rx_cnt += 1.
- Candidate while full with no pop: newest packet discarded; drop_cnt += 1; ovf ← 1. FIFO contents are never overwritten.
- Pop: out_valid && out_ready → head advances. out_ready while empty has no effect.
- Simultaneous write and pop: count unchanged; order preserved.
- FIFO control states: EMPTY (count=0), PARTIAL, FULL (count=DEPTH), derived from count.
  - Transitions: EMPTY→PARTIAL on write.
  - PARTIAL→FULL on write without pop.
  - FULL→PARTIAL on pop.
  - PARTIAL→EMPTY on pop without write, when count was 1.
  - DEPTH=2 permits EMPTY↔FULL through PARTIAL only.
- Pointers: $clog2(DEPTH)-bit read and write pointers; wrap modulo DEPTH; occupancy tracked by count, not by pointer compare.
- Counters saturate and do not wrap. One push event increments exactly one of rx_cnt or drop_cnt.
- X on D_push is a don't-care when push=0.

## Timing
- Reset values: out_valid=0, pndng=0, out_data=0, count=0, ovf=0, rx_cnt=0, drop_cnt=0; pointers 0.
- rst is sampled at posedge and has priority over everything else.
- A push or pop in the same cycle as rst is ignored.
- Reset mid-operation flushes the FIFO with no partial state retained.
- Latency: push at edge N into an empty FIFO → out_valid=1 and out_data=packet after edge N; no combinational path from push to out_*.
- out_data is stable while out_valid=1 and no pop occurs. After a pop, the next head appears the following cycle with no bubble.
- Statistics update at the same edge as the push that causes them.
- count, ovf, rx_cnt and drop_cnt are registered outputs.

## Structure
- Shared package bus_pkg:
  - BCAST_ID constant
  - ID_W=8
  - function pkt_id(pkt) returning the ID field
  - typedef for the statistics counter (16-bit)
- The transmit-side bus agents use this package too.
- One sub-module, sync_fifo_fwft (parameters WIDTH, DEPTH), holds storage, pointers, count, full and empty. The top level holds the filter, overflow logic and counters.

## Test plan
Defaults unless stated: drvrs=4, pckg_sz=16, MY_ID=2, DEPTH=4.
- Reset: after rst, push 16'h02AB at edge N → out_valid=1 and out_data=16'h02AB after edge N; rx_cnt=1, drop_cnt=0.
- Filter: push 16'h01CD, then 16'hFF11, then 16'h0233 with out_ready=0 → FIFO holds FF11 then 0233; rx_cnt=2, drop_cnt=1; ovf=0.
- Overflow: 6 pushes with ID 02 and payloads 00..05, out_ready=0 → count=4; head=16'h0200; drop_cnt=2; ovf=1. Pop all → payloads 00..03 in order, then out_valid=0.
- Full plus simultaneous push and pop: fill to 4, then push 16'h0277 with out_ready=1 → count stays 4; no drop; 0277 is the last packet drained.
- Wrap-around: 10 rounds of push 2 / pop 2 with payloads incrementing → every packet out in order; rx_cnt=20; pointers wrap with no loss.
- Reset mid-operation: count=3, assert rst for 1 cycle with push=1 → count=0, out_valid=0, all counters 0; the pushed packet does not appear.
